// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard unit.
package hazard_pkg;
    localparam int REG_AW_DEF = 5;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_e;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} haz_state_e;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: one operand channel's bypass choice, memory stage winning over writeback.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] m_rd_addr,
    input  logic              m_gpr_wen,
    input  logic [REG_AW-1:0] w_rd_addr,
    input  logic              w_gpr_wen,
    output logic [1:0]        sel
);
    logic m_hit, w_hit;
    assign m_hit = m_gpr_wen && (m_rd_addr != '0) && (m_rd_addr == rs_addr);
    assign w_hit = w_gpr_wen && (w_rd_addr != '0) && (w_rd_addr == rs_addr);
    assign sel   = m_hit ? FWD_M : (w_hit ? FWD_W : FWD_RF);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use stall, redirect flush and memory wait/timeout control.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] D_rs_addr,
    input  logic [NUM_SRC*REG_AW-1:0] E_rs_addr,
    input  logic [REG_AW-1:0]         E_rd_addr,
    input  logic                      E_is_load,
    input  logic                      E_pc_redirect,
    input  logic [REG_AW-1:0]         M_rd_addr,
    input  logic                      M_gpr_wen,
    input  logic                      M_mem_req,
    input  logic                      M_mem_ready,
    input  logic [REG_AW-1:0]         W_rd_addr,
    input  logic                      W_gpr_wen,
    output logic [2*NUM_SRC-1:0]      E_forward_sel,
    output logic                      F_stall,
    output logic                      D_stall,
    output logic                      E_stall,
    output logic                      M_stall,
    output logic                      D_flush,
    output logic                      E_flush,
    output logic                      W_flush,
    output logic                      halted,
    output logic                      mem_timeout,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_events
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    haz_state_e    state, state_nx;
    logic [CW-1:0] wait_cnt, cnt_nx;
    logic          tmo_nx, mem_hold, load_use, d_match, hold_all, redir, lu_stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        logic [1:0] sel;
        fwd_select #(.REG_AW(REG_AW)) u_fwd (
            .rs_addr   (E_rs_addr[i*REG_AW +: REG_AW]),
            .m_rd_addr (M_rd_addr),
            .m_gpr_wen (M_gpr_wen),
            .w_rd_addr (W_rd_addr),
            .w_gpr_wen (W_gpr_wen),
            .sel       (sel)
        );
        assign E_forward_sel[2*i +: 2] = reset ? sel : 2'b00;
    end

    always_comb begin
        d_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            d_match = d_match | (D_rs_addr[i*REG_AW +: REG_AW] == E_rd_addr);
    end

    assign mem_hold = M_mem_req && !M_mem_ready;
    assign load_use = E_is_load && (E_rd_addr != '0) && d_match;
    // Memory hold masks redirect and load-use; they re-present after release.
    assign hold_all = reset && ((state == HALT) || mem_hold);
    assign redir    = reset && !hold_all && E_pc_redirect;
    assign lu_stall = reset && !hold_all && !E_pc_redirect && load_use;

    assign F_stall = hold_all | lu_stall;
    assign D_stall = hold_all | lu_stall;
    assign E_stall = hold_all;
    assign M_stall = hold_all;
    assign W_flush = hold_all;
    assign D_flush = redir;
    assign E_flush = redir | lu_stall;
    assign halted  = (state == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= cnt_nx;
            mem_timeout <= tmo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = wait_cnt;
        tmo_nx   = mem_timeout;
        case (state)
            RUN: begin
                if (mem_hold) begin
                    state_nx = MEM_WAIT;
                    cnt_nx   = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_hold) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else if (wait_cnt == LAST) begin
                    state_nx = HALT;
                    tmo_nx   = 1'b1;
                end else begin
                    cnt_nx = wait_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (F_stall) stall_q <= stall_q + 32'd1;
            if (D_flush | E_flush) flush_q <= flush_q + 32'd1;
        end
    end
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus, per-cycle comparison against a rule-level model.
module tb_pipeline_hazard_ctrl;
    localparam int NS = 3;
    localparam int AW = 5;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS*AW-1:0] D_rs_addr, E_rs_addr;
    logic [AW-1:0]    E_rd_addr, M_rd_addr, W_rd_addr;
    logic             E_is_load, E_pc_redirect, M_gpr_wen, M_mem_req, M_mem_ready, W_gpr_wen;
    logic [2*NS-1:0]  E_forward_sel;
    logic             F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, W_flush, halted, mem_timeout;
    logic [31:0]      stall_cycles, flush_events;

    pipeline_hazard_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .E_rs_addr(E_rs_addr),
        .E_rd_addr(E_rd_addr), .E_is_load(E_is_load), .E_pc_redirect(E_pc_redirect),
        .M_rd_addr(M_rd_addr), .M_gpr_wen(M_gpr_wen), .M_mem_req(M_mem_req), .M_mem_ready(M_mem_ready),
        .W_rd_addr(W_rd_addr), .W_gpr_wen(W_gpr_wen),
        .E_forward_sel(E_forward_sel),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
        .D_flush(D_flush), .E_flush(E_flush), .W_flush(W_flush),
        .halted(halted), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: consecutive not-ready count, halt flag, sticky timeout, perf totals.
    int          nr_cnt = 0;
    bit          halted_m = 0, tmo_m = 0;
    int unsigned sc_m = 0, fe_m = 0;
    logic [2*NS-1:0] x_fwd;
    logic        x_f, x_d, x_e, x_m, x_df, x_ef, x_wf, x_h, x_t, hold, lu;
    logic [AW-1:0] rs_e [NS];
    logic [AW-1:0] rs_d [NS];

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            rs_e[i] = E_rs_addr[i*AW +: AW];
            rs_d[i] = D_rs_addr[i*AW +: AW];
        end
        lu = 1'b0;
        x_fwd = '0;
        for (int i = 0; i < NS; i++) begin
            if (E_is_load && E_rd_addr != 0 && rs_d[i] == E_rd_addr) lu = 1'b1;
            if (!reset) x_fwd[2*i +: 2] = 2'b00;
            else if (M_gpr_wen && M_rd_addr != 0 && M_rd_addr == rs_e[i]) x_fwd[2*i +: 2] = 2'b10;
            else if (W_gpr_wen && W_rd_addr != 0 && W_rd_addr == rs_e[i]) x_fwd[2*i +: 2] = 2'b01;
        end
        hold = halted_m || (M_mem_req && !M_mem_ready);
        {x_f, x_d, x_e, x_m, x_df, x_ef, x_wf} = '0;
        x_h = reset && halted_m;
        x_t = reset && tmo_m;
        if (reset) begin
            if (hold) {x_f, x_d, x_e, x_m, x_wf} = '1;
            else if (E_pc_redirect) {x_df, x_ef} = '1;
            else if (lu) {x_f, x_d, x_ef} = '1;
        end
        chk("fwd", 32'(E_forward_sel), 32'(x_fwd));
        chk("ctl", 32'({F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, W_flush, halted, mem_timeout}),
                   32'({x_f, x_d, x_e, x_m, x_df, x_ef, x_wf, x_h, x_t}));
`ifdef HAZARD_PERF_EN
        chk("stall_cycles", stall_cycles, reset ? sc_m : 32'd0);
        chk("flush_events", flush_events, reset ? fe_m : 32'd0);
`else
        chk("stall_cycles", stall_cycles, 32'd0);
        chk("flush_events", flush_events, 32'd0);
`endif
        if (!reset) begin
            nr_cnt = 0; halted_m = 0; tmo_m = 0; sc_m = 0; fe_m = 0;
        end else begin
            if (x_f) sc_m++;
            if (x_df || x_ef) fe_m++;
            if (!halted_m) begin
                nr_cnt = (M_mem_req && !M_mem_ready) ? nr_cnt + 1 : 0;
                if (nr_cnt == TO) begin halted_m = 1; tmo_m = 1; end
            end
        end
    end

    task automatic idle();
        D_rs_addr = '0; E_rs_addr = '0; E_rd_addr = '0; M_rd_addr = '0; W_rd_addr = '0;
        E_is_load = 0; E_pc_redirect = 0; M_gpr_wen = 0; M_mem_req = 0; M_mem_ready = 0; W_gpr_wen = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] snap;

    initial begin
        reset = 1'b1;
        idle();
        #1 reset = 1'b0;
        M_mem_req = 1; E_is_load = 1; E_rd_addr = 7; D_rs_addr[AW +: AW] = 7;
        M_rd_addr = 5; M_gpr_wen = 1; E_rs_addr[0 +: AW] = 5;
        #2;
        chk("rst_fstall", 32'(F_stall), 0);
        chk("rst_wflush", 32'(W_flush), 0);
        chk("rst_fwd", 32'(E_forward_sel), 0);
        cyc(2);
        idle();
        reset = 1'b1;
        cyc(1);
        // Forwarding: M over W, then W alone, then channel 2, then x0.
        M_rd_addr = 5; M_gpr_wen = 1; W_rd_addr = 5; W_gpr_wen = 1; E_rs_addr = {5'd0, 5'd0, 5'd5};
        #2 chk("fwd_m_over_w", 32'(E_forward_sel), 32'(6'b000010));
        cyc(1);
        M_gpr_wen = 0;
        #2 chk("fwd_w", 32'(E_forward_sel), 32'(6'b000001));
        cyc(1);
        M_rd_addr = 3; M_gpr_wen = 1; W_rd_addr = 9; E_rs_addr = {5'd9, 5'd0, 5'd3};
        #2 chk("fwd_ch2_w", 32'(E_forward_sel), 32'(6'b010010));
        cyc(1);
        M_rd_addr = 0; W_rd_addr = 0; E_rs_addr = '0;
        #2 chk("fwd_x0", 32'(E_forward_sel), 0);
        cyc(1);
        // Load-use on channel 1, suppressed for x0, then channel 2.
        idle();
        E_is_load = 1; E_rd_addr = 7; D_rs_addr = {5'd0, 5'd7, 5'd0};
        #2 chk("lu_ch1", 32'({F_stall, D_stall, E_stall, E_flush, D_flush}), 32'(5'b11010));
        cyc(1);
        E_rd_addr = 0; D_rs_addr = '0;
        #2 chk("lu_x0", 32'({F_stall, D_stall, E_flush}), 0);
        cyc(1);
        E_rd_addr = 9; D_rs_addr = {5'd9, 5'd0, 5'd0};
        #2 chk("lu_ch2", 32'({F_stall, D_stall, E_flush}), 32'(3'b111));
        cyc(1);
        // Redirect beats a coincident load-use.
        E_pc_redirect = 1;
        #2 chk("redir", 32'({F_stall, D_stall, D_flush, E_flush}), 32'(4'b0011));
        snap = flush_events;
        cyc(1);
        idle();
        #2;
`ifdef HAZARD_PERF_EN
        chk("flush_delta", flush_events - snap, 1);
`else
        chk("flush_off", flush_events, 0);
`endif
        snap = stall_cycles;
        cyc(1);
        // Three not-ready cycles with a masked redirect, then ready.
        M_mem_req = 1; E_pc_redirect = 1;
        for (int k = 0; k < 3; k++) begin
            #2 chk("mem_hold", 32'({F_stall, D_stall, E_stall, M_stall, W_flush, D_flush}), 32'(6'b111110));
            cyc(1);
        end
        M_mem_ready = 1; E_pc_redirect = 0;
        #2 chk("mem_release", 32'({F_stall, M_stall, halted, mem_timeout}), 0);
        cyc(1);
        idle();
        #2;
`ifdef HAZARD_PERF_EN
        chk("stall_delta", stall_cycles - snap, 3);
`endif
        chk("mem_back_run", 32'({halted, mem_timeout}), 0);
        cyc(1);
        // Dropping the request restarts the not-ready count.
        M_mem_req = 1; cyc(3);
        M_mem_req = 0; cyc(1);
        M_mem_req = 1; cyc(3);
        #2 chk("no_halt_restart", 32'({halted, mem_timeout}), 0);
        M_mem_req = 0;
        cyc(1);
        // Timeout: halt after the 4th not-ready edge.
        M_mem_req = 1;
        cyc(3);
        #2 chk("pre_halt", 32'(halted), 0);
        cyc(1);
        #2 chk("halt", 32'({halted, mem_timeout, F_stall, W_flush}), 32'(4'b1111));
        cyc(1);
        idle();
        W_rd_addr = 4; W_gpr_wen = 1; E_rs_addr = {5'd0, 5'd4, 5'd0};
        #2 chk("halt_sticky", 32'({halted, mem_timeout, M_stall, W_flush, D_flush}), 32'(5'b11110));
        chk("halt_fwd", 32'(E_forward_sel), 32'(6'b000100));
        cyc(2);
        reset = 1'b0;
        #2 chk("reset_mid_halt", 32'({halted, mem_timeout, F_stall, W_flush, E_forward_sel}), 0);
        cyc(1);
        reset = 1'b1;
        idle();
        cyc(1);
        #2 chk("after_reset", 32'({halted, mem_timeout, F_stall}), 0);
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Next-generation hazard unit for the 5-stage RV32 pipeline. It sits beside the controller and data path inside the processor top.
- Generalises the forward-only unit in four ways: NUM_SRC operand channels, load-use stall, branch/jump flush, and data-memory wait-state stalling with a timeout watchdog.
- Forwarding and stall/flush outputs are combinational from stage fields plus the registered FSM state. Only the FSM, wait counter and sticky error are sequential.

Parameters:
- NUM_SRC, 2, number of register source operands checked per instruction (≥1).
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 16, consecutive not-ready memory cycles before HALT (≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- D_rs_addr  in  NUM_SRC*REG_AW  decode-stage source addresses; channel i at [i*REG_AW +: REG_AW].
- E_rs_addr  in  NUM_SRC*REG_AW  execute-stage source addresses.
- E_rd_addr  in  REG_AW  execute-stage destination.
- E_is_load  in  1  execute-stage instruction is a load.
- E_pc_redirect  in  1  branch taken or jump resolved in E.
- M_rd_addr  in  REG_AW  memory-stage destination.
- M_gpr_wen  in  1  memory-stage instruction writes the GPR.
- M_mem_req  in  1  memory-stage load/store active.
- M_mem_ready  in  1  data memory completes this cycle.
- W_rd_addr  in  REG_AW  writeback destination.
- W_gpr_wen  in  1  writeback GPR write enable.
- E_forward_sel  out  2*NUM_SRC  per-channel select: 00 regfile, 01 W, 10 M.
- F_stall, D_stall, E_stall, M_stall  out  1 each  hold the corresponding pipeline register.
- D_flush, E_flush, W_flush  out  1 each  insert a bubble into the corresponding pipeline register.
- halted  out  1  FSM in HALT.
- mem_timeout  out  1  sticky timeout error.
- stall_cycles, flush_events  out  32 each  performance counters.

Behaviour:
- Reset (low, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, counters=0. While reset is low, all stalls/flushes=0, E_forward_sel=0, halted=0.
- Forwarding, per channel i, combinational:
  - M_gpr_wen && M_rd≠0 && M_rd==E_rs[i] → 10;
  - else W_gpr_wen && W_rd≠0 && W_rd==E_rs[i] → 01;
  - else 00.
  - M has priority over W. Forwarding is active in every state.
- mem_hold = M_mem_req && !M_mem_ready.
- load_use = E_is_load && E_rd≠0 && E_rd equals any D_rs[i].
- Outputs, priority high→low:
  1. state==HALT: F/D/E/M_stall=1, W_flush=1, all other flushes 0, halted=1.
  2. mem_hold (RUN or MEM_WAIT): F/D/E/M_stall=1, W_flush=1. Redirect and load-use are masked; they re-present once the pipeline is released.
  3. E_pc_redirect: D_flush=1, E_flush=1, no stalls. Any coincident load-use is discarded, because the younger instruction is squashed.
  4. load_use: F_stall=1, D_stall=1, E_flush=1 for exactly one cycle.
  5. else: all stall/flush outputs 0.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN: on mem_hold → MEM_WAIT, wait_cnt←1.
  - MEM_WAIT:
    - M_mem_ready → RUN, wait_cnt←0; no mem stall in that cycle.
    - !M_mem_ready && wait_cnt==MEM_TIMEOUT−1 → HALT, mem_timeout←1.
    - otherwise wait_cnt←wait_cnt+1.
  - MEM_WAIT with M_mem_req dropped: treated as ready, return to RUN.
  - HALT: exits only via reset.
- Timeout edge: HALT entry is at the clock edge ending the MEM_TIMEOUT-th consecutive not-ready cycle.
- wait_cnt width: $clog2(MEM_TIMEOUT+1).
- Reset mid-MEM_WAIT or mid-HALT returns to RUN and clears mem_timeout.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cycles increments each cycle F_stall==1.
  - flush_events increments each cycle D_flush|E_flush.
  - Both are 32-bit and wrap 0xFFFFFFFF→0.
- Undefined: both outputs are tied to constant 0 and no counter flops are built.

Decomposition:
- hazard_pkg:
  - fwd_sel_e (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - haz_state_e (RUN, MEM_WAIT, HALT).
  - Shared REG_AW default.
- Sub-module fwd_select: one channel's M/W priority compare. Generate NUM_SRC instances.

Test Plan:
- M_rd=5, M_gpr_wen=1, W_rd=5, W_gpr_wen=1, E_rs[0]=5, E_rs[1]=0 → E_forward_sel=4'b0010 (ch0=M, ch1=RF). Repeat with M_gpr_wen=0 → ch0=01.
- E_is_load=1, E_rd=7, D_rs[1]=7 → F_stall=D_stall=E_flush=1 for one cycle. Same with E_rd=0 → all 0.
- E_pc_redirect=1 with a coincident load-use → D_flush=E_flush=1, F_stall=0. With HAZARD_PERF_EN, flush_events increments by 1.
- M_mem_req=1, M_mem_ready low for 3 cycles then high → all stalls + W_flush for 3 cycles, state returns to RUN, mem_timeout=0. With HAZARD_PERF_EN, stall_cycles increases by 3.
- MEM_TIMEOUT=4, M_mem_ready held low → HALT entered after 4th not-ready edge; halted=mem_timeout=1 persists. Assert reset low mid-HALT → all outputs 0, state RUN.
- NUM_SRC=3 build: E_rs[2]=W_rd=9, W_gpr_wen=1 → E_forward_sel[5:4]=01. D_rs[2]=E_rd=9 with E_is_load=1 → load-use stall.
